csr_access_seq: RTL and testbench

Multi-cycle sequencer for Zicsr instructions (CSRRW/RS/RC and the immediate forms CSRRWI/RSI/RCI). It sits between decode and the CSR register file. It accepts one decoded SYSTEM/CSR request at a time and performs the read, modify and conditional write against the CSR file. It returns the old CSR value for rd writeback, or flags an exception. Operand selection follows the funct3 input-select bit: bit 2 set selects the zero-extended 5-bit rs1 field (zimm); bit 2 clear selects the rs1 register value.

---
 rtl/csr_access_seq.sv | 184 ++++++++++++++++++
 tb/tb_csr_access_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_seq.sv
// csr_access_seq: read / modify / conditional-write sequencer for Zicsr instructions.
// Define CSR_SEQ_IMM_EN to support the immediate forms (CSRRWI/CSRRSI/CSRRCI).
module csr_access_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_csr_addr,
  input  logic [4:0]      req_rs1,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [4:0]      req_rd,
  output logic            csr_rd_en,
  output logic            csr_wr_en,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic            csr_illegal,
  output logic            done_valid,
  input  logic            done_ready,
  output logic            done_rd_en,
  output logic [XLEN-1:0] done_rd_data,
  output logic            done_exception
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;

  state_t          state_r;
  state_t          state_next_s;
  logic [1:0]      op_r;
  logic            imm_r;
  logic [11:0]     addr_r;
  logic [4:0]      rs1_r;
  logic [XLEN-1:0] rs1_val_r;
  logic [4:0]      rd_r;
  logic            done_rd_en_r;
  logic            done_exc_r;
  logic [XLEN-1:0] done_data_r;

  logic            accept_s;
  logic            imm_bad_s;
  logic            early_exc_s;
  logic            attempt_s;
  logic            exc_s;
  logic [XLEN-1:0] src_s;
  logic [XLEN-1:0] new_val_s;
  logic            done_load_s;
  logic            done_rd_en_next_s;
  logic            done_exc_next_s;
  logic [XLEN-1:0] done_data_next_s;

`ifdef CSR_SEQ_IMM_EN
  assign imm_bad_s = 1'b0;
`else
  assign imm_bad_s = req_funct3[2];
`endif

  // Requests that can never access the CSR file complete straight from IDLE.
  assign early_exc_s = (req_funct3[1:0] == 2'b00) || imm_bad_s;
  assign accept_s    = (state_r == IDLE) && req_valid && !flush;

  assign src_s     = imm_r ? {{(XLEN-5){1'b0}}, rs1_r} : rs1_val_r;
  assign attempt_s = (op_r == OP_RW) || (rs1_r != 5'd0);
  assign exc_s     = csr_illegal || (attempt_s && (addr_r[11:10] == 2'b11));

  assign done_valid     = (state_r == DONE);
  assign done_rd_en     = done_rd_en_r;
  assign done_rd_data   = done_data_r;
  assign done_exception = done_exc_r;

  // Modify step: combine the old CSR value with the source operand.
  always_comb begin
    new_val_s = csr_rdata & ~src_s;
    case (op_r)
      OP_RW:   new_val_s = src_s;
      OP_RS:   new_val_s = csr_rdata | src_s;
      default: new_val_s = csr_rdata & ~src_s;
    endcase
  end

  // Next-state logic, CSR strobes and result capture values.
  always_comb begin
    state_next_s      = state_r;
    req_ready         = 1'b0;
    csr_rd_en         = 1'b0;
    csr_wr_en         = 1'b0;
    csr_addr          = 12'd0;
    csr_wdata         = '0;
    done_load_s       = 1'b0;
    done_rd_en_next_s = 1'b0;
    done_exc_next_s   = 1'b0;
    done_data_next_s  = '0;
    case (state_r)
      IDLE: begin
        req_ready = !flush;
        if (accept_s) begin
          if (early_exc_s) begin
            state_next_s    = DONE;
            done_load_s     = 1'b1;
            done_exc_next_s = 1'b1;
          end else begin
            state_next_s = READ;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      READ: begin
        csr_addr     = addr_r;
        csr_rd_en    = !((op_r == OP_RW) && (rd_r == 5'd0));
        state_next_s = flush ? IDLE : WRITE;
      end
      WRITE: begin
        csr_addr  = addr_r;
        csr_wr_en = attempt_s && !exc_s && !flush;
        csr_wdata = (attempt_s && !exc_s && !flush) ? new_val_s : '0;
        if (flush) begin
          state_next_s = IDLE;
        end else begin
          state_next_s      = DONE;
          done_load_s       = 1'b1;
          done_exc_next_s   = exc_s;
          done_rd_en_next_s = (rd_r != 5'd0) && !exc_s;
          done_data_next_s  = csr_rdata;
        end
      end
      DONE: begin
        if (flush || done_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, latched request fields and registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      op_r         <= 2'b00;
      imm_r        <= 1'b0;
      addr_r       <= 12'd0;
      rs1_r        <= 5'd0;
      rs1_val_r    <= '0;
      rd_r         <= 5'd0;
      done_rd_en_r <= 1'b0;
      done_exc_r   <= 1'b0;
      done_data_r  <= '0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        op_r      <= req_funct3[1:0];
        imm_r     <= req_funct3[2];
        addr_r    <= req_csr_addr;
        rs1_r     <= req_rs1;
        rs1_val_r <= req_rs1_val;
        rd_r      <= req_rd;
      end
      if (done_load_s) begin
        done_rd_en_r <= done_rd_en_next_s;
        done_exc_r   <= done_exc_next_s;
        done_data_r  <= done_data_next_s;
      end else if (state_next_s == IDLE) begin
        done_rd_en_r <= 1'b0;
        done_exc_r   <= 1'b0;
        done_data_r  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_csr_access_seq.sv
// Self-checking bench for csr_access_seq: directed cases, random requests against a
// rule-level reference model, back-pressure, flush and mid-transaction reset.
module tb_csr_access_seq;
  localparam int XLEN = 32;
`ifdef CSR_SEQ_IMM_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [11:0]     req_csr_addr;
  logic [4:0]      req_rs1;
  logic [XLEN-1:0] req_rs1_val;
  logic [4:0]      req_rd;
  logic            csr_rd_en;
  logic            csr_wr_en;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            done_valid;
  logic            done_ready;
  logic            done_rd_en;
  logic [XLEN-1:0] done_rd_data;
  logic            done_exception;

  int n_cmp  = 0;
  int n_fail = 0;

  csr_access_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_csr_addr(req_csr_addr), .req_rs1(req_rs1), .req_rs1_val(req_rs1_val), .req_rd(req_rd),
    .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .done_valid(done_valid), .done_ready(done_ready), .done_rd_en(done_rd_en),
    .done_rd_data(done_rd_data), .done_exception(done_exception)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached after %0d comparisons", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // One request through the DUT, every cycle checked against the rule-level model.
  task automatic do_txn(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                        input logic [31:0] val, input logic [4:0] rd, input logic [31:0] rdata,
                        input logic ill, input int hold);
    logic [1:0]  op;
    logic        imm, early, attempt, exc, exp_wr, exp_rd, exp_rd_en;
    logic [31:0] src, nv, exp_data, r;
    int          waited;
    op      = f3[1:0];
    imm     = f3[2];
    early   = (op == 2'b00) || (imm && !IMM_EN);
    src     = imm ? {27'd0, rs1} : val;
    if (op == 2'b01) nv = src;
    else if (op == 2'b10) nv = rdata | src;
    else nv = rdata & ~src;
    attempt   = (op == 2'b01) || (rs1 != 5'd0);
    exc       = early || ill || (attempt && (addr[11:10] == 2'b11));
    exp_wr    = !early && attempt && !exc;
    exp_rd    = !early && !((op == 2'b01) && (rd == 5'd0));
    exp_rd_en = (rd != 5'd0) && !exc;
    exp_data  = early ? 32'd0 : rdata;

    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_wait: req_ready=%b, required 1 within 20 cycles", req_ready);
    end

    req_valid = 1'b1; req_funct3 = f3; req_csr_addr = addr;
    req_rs1 = rs1; req_rs1_val = val; req_rd = rd;
    @(posedge clk); #1;
    r = $urandom;
    req_valid = 1'b0; req_funct3 = r[2:0]; req_csr_addr = r[14:3];
    req_rs1 = r[19:15]; req_rs1_val = $urandom; req_rd = r[24:20];
    csr_rdata = $urandom; csr_illegal = r[25];

    if (!early) begin
      @(negedge clk);
      n_cmp++;
      if ({csr_rd_en, csr_wr_en, done_valid, req_ready, csr_addr, csr_wdata} !==
          {exp_rd, 3'b000, addr, 32'd0}) begin
        n_fail++;
        $display("FAIL read_cycle: rd/wr/dv/rdy=%b%b%b%b addr=%h wdata=%h, required %b000 addr=%h wdata=0",
                 csr_rd_en, csr_wr_en, done_valid, req_ready, csr_addr, csr_wdata, exp_rd, addr);
      end
      @(posedge clk); #1;
      csr_rdata = rdata; csr_illegal = ill;
      @(negedge clk);
      n_cmp++;
      if ({csr_rd_en, csr_wr_en, done_valid, req_ready, csr_addr, csr_wdata} !==
          {1'b0, exp_wr, 2'b00, addr, (exp_wr ? nv : 32'd0)}) begin
        n_fail++;
        $display("FAIL write_cycle: rd/wr/dv/rdy=%b%b%b%b addr=%h wdata=%h, required 0%b00 addr=%h wdata=%h",
                 csr_rd_en, csr_wr_en, done_valid, req_ready, csr_addr, csr_wdata,
                 exp_wr, addr, (exp_wr ? nv : 32'd0));
      end
      @(posedge clk); #1;
      r = $urandom;
      csr_rdata = $urandom; csr_illegal = r[0];
    end

    for (int h = 0; h <= hold; h++) begin
      done_ready = (h == hold);
      @(negedge clk);
      n_cmp++;
      if ({csr_rd_en, csr_wr_en, done_valid, req_ready, done_rd_en, done_exception, done_rd_data} !==
          {4'b0010, exp_rd_en, exc, exp_data}) begin
        n_fail++;
        $display("FAIL done_cycle%0d: rd/wr/dv/rdy=%b%b%b%b rd_en=%b exc=%b data=%h, required 0010 rd_en=%b exc=%b data=%h",
                 h, csr_rd_en, csr_wr_en, done_valid, req_ready, done_rd_en, done_exception,
                 done_rd_data, exp_rd_en, exc, exp_data);
      end
      @(posedge clk); #1;
    end
    done_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({csr_rd_en, csr_wr_en, done_valid, req_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL back_to_idle: rd/wr/dv/rdy=%b%b%b%b, required 0001",
               csr_rd_en, csr_wr_en, done_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_funct3 = 3'd0; req_csr_addr = 12'd0;
    req_rs1 = 5'd0; req_rs1_val = 32'd0; req_rd = 5'd0; csr_rdata = 32'd0;
    csr_illegal = 1'b0; done_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_ready, csr_rd_en, csr_wr_en, done_valid, done_rd_en, done_exception,
         csr_addr, csr_wdata, done_rd_data} !== {6'b100000, 12'd0, 64'd0}) begin
      n_fail++;
      $display("FAIL reset_values: rdy/rd/wr/dv/rden/exc=%b%b%b%b%b%b addr=%h wdata=%h data=%h, required 100000 and zeros",
               req_ready, csr_rd_en, csr_wr_en, done_valid, done_rd_en, done_exception,
               csr_addr, csr_wdata, done_rd_data);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    do_txn(3'b010, 12'h300, 5'd5, 32'h0000_0008, 5'd3, 32'h0000_1800, 1'b0, 0);
    do_txn(3'b111, 12'h300, 5'd0, 32'h1234_5678, 5'd7, 32'hFFFF_FFFF, 1'b0, 0);
    do_txn(3'b001, 12'h340, 5'd9, 32'hDEAD_BEEF, 5'd0, 32'h0000_00AA, 1'b0, 0);
    do_txn(3'b001, 12'hC00, 5'd4, 32'h0000_0001, 5'd2, 32'h0000_0055, 1'b0, 0);
    do_txn(3'b010, 12'h7FF, 5'd1, 32'h0000_0001, 5'd6, 32'h0000_0077, 1'b1, 0);
    do_txn(3'b000, 12'h300, 5'd1, 32'h0000_0001, 5'd6, 32'h0000_0077, 1'b0, 0);
    do_txn(3'b101, 12'h305, 5'd17, 32'h0, 5'd8, 32'hA5A5_0000, 1'b0, 0);
    do_txn(3'b011, 12'hC01, 5'd0, 32'hFFFF_FFFF, 5'd1, 32'h0BAD_F00D, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    do_txn(3'b011, 12'h344, 5'd2, 32'h0000_00F0, 5'd4, 32'h0000_0FFF, 1'b0, 5);
    do_txn(3'b001, 12'h341, 5'd3, 32'h8000_0004, 5'd5, 32'h1111_2222, 1'b0, 0);
  endtask

  task automatic test_random;
    logic [31:0] r;
    logic [11:0] a;
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      a = r[11:0];
      if (r[13:12] == 2'b00) a[11:10] = 2'b11;
      do_txn(r[16:14], a, (r[18:17] == 2'b00) ? 5'd0 : r[23:19],
             $urandom, (r[25:24] == 2'b00) ? 5'd0 : r[30:26],
             $urandom, (r[31] && r[0]), int'(r[3:2]));
    end
  endtask

  task automatic test_flush;
    flush = 1'b1; req_valid = 1'b1; req_funct3 = 3'b001; req_csr_addr = 12'h340;
    req_rs1 = 5'd1; req_rs1_val = 32'h1; req_rd = 5'd1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_ready: req_ready=%b, required 0", req_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({csr_rd_en, done_valid, req_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL flush_idle_noaccept: rd/dv/rdy=%b%b%b, required 001", csr_rd_en, done_valid, req_ready);
    end
    req_valid = 1'b1; req_funct3 = 3'b001; req_csr_addr = 12'h340;
    req_rs1_val = 32'hCAFE_F00D; req_rd = 5'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1; csr_rdata = 32'h1234_0000; csr_illegal = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({csr_wr_en, req_ready, csr_wdata} !== {2'b00, 32'd0}) begin
      n_fail++;
      $display("FAIL flush_write: wr=%b rdy=%b wdata=%h, required wr=0 rdy=0 wdata=0",
               csr_wr_en, req_ready, csr_wdata);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({done_valid, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_write_drop: dv=%b rdy=%b, required dv=0 rdy=1", done_valid, req_ready);
    end
    req_valid = 1'b1; req_funct3 = 3'b000;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({done_valid, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_done_drop: dv=%b rdy=%b, required dv=0 rdy=1", done_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; req_funct3 = 3'b010; req_csr_addr = 12'h300;
    req_rs1 = 5'd5; req_rs1_val = 32'h8; req_rd = 5'd3;
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b1; flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (csr_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_read: csr_rd_en=%b, required 1", csr_rd_en);
    end
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, csr_rd_en, csr_wr_en, done_valid, done_rd_en, done_exception,
         csr_addr, csr_wdata, done_rd_data} !== {6'b100000, 12'd0, 64'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_values: rdy/rd/wr/dv/rden/exc=%b%b%b%b%b%b addr=%h wdata=%h data=%h, required 100000 and zeros",
               req_ready, csr_rd_en, csr_wr_en, done_valid, done_rd_en, done_exception,
               csr_addr, csr_wdata, done_rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    test_directed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
